// File: rtl/conf_uart_tx_pkg.sv
// Shared configuration-UART definitions: sizes, bit timing, tx state encoding.
// Also defines the CONF_BUS_W flattened-bus width macro.
`ifndef CONF_UART_TX_PKG_SV
`define CONF_UART_TX_PKG_SV

`define CONF_BUS_W(n) ((n) * 8)

package conf_uart_tx_pkg;

    localparam int unsigned CLK_FREQ_HZ      = 50_000_000;
    localparam int unsigned BAUD_RATE        = 9600;
    localparam int unsigned BIT_CLK_MAX      = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CONF_PAR_MAX     = 4;
    localparam int unsigned DATA_BIT_CNT_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } tx_state_t;

endpackage

`endif

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..CNT_MAX-1, one-cycle tick on the wrap.
// Synchronous clear holds it at zero; shared by the tx and rx sides.
module uart_baud_tick #(
    parameter int unsigned CNT_MAX = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(CNT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/conf_uart_tx.sv
// Configuration readback UART: snapshots the parameter bytes and sends them 8N1.
// Define CONF_TX_CHECKSUM_EN to append an XOR checksum frame.
module conf_uart_tx
    import conf_uart_tx_pkg::*;
#(
    parameter int unsigned CONF_PAR_MAX = conf_uart_tx_pkg::CONF_PAR_MAX,
    parameter int unsigned BIT_CLK_MAX  = conf_uart_tx_pkg::BIT_CLK_MAX
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [`CONF_BUS_W(CONF_PAR_MAX)-1:0] par_data,
    output logic                                 uart_tx,
    output logic                                 busy,
    output logic                                 done
);

`ifdef CONF_TX_CHECKSUM_EN
    localparam int unsigned N_FRAMES = CONF_PAR_MAX + 1;
`else
    localparam int unsigned N_FRAMES = CONF_PAR_MAX;
`endif
    localparam int unsigned IDX_W = $clog2(N_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FRAMES - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BIT_CNT_MAX - 1);

    tx_state_t                            state;
    logic [`CONF_BUS_W(CONF_PAR_MAX)-1:0] shadow;
    logic [IDX_W-1:0]                     idx;
    logic [2:0]                           bit_idx;
    logic [7:0]                           cur_byte;
    logic                                 tick;

    uart_baud_tick #(
        .CNT_MAX(BIT_CLK_MAX)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == IDLE),
        .tick (tick)
    );

`ifdef CONF_TX_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = '0;
        for (int k = 0; k < int'(CONF_PAR_MAX); k++) begin
            csum = csum ^ shadow[k*8 +: 8];
        end
    end
`endif

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < int'(CONF_PAR_MAX); k++) begin
            if (idx == IDX_W'(k)) cur_byte = shadow[k*8 +: 8];
        end
`ifdef CONF_TX_CHECKSUM_EN
        if (idx == IDX_W'(CONF_PAR_MAX)) cur_byte = csum;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shadow  <= '0;
            idx     <= '0;
            bit_idx <= '0;
            uart_tx <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shadow  <= par_data;
                        idx     <= '0;
                        bit_idx <= '0;
                        uart_tx <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (tick) begin
                        uart_tx <= cur_byte[0];
                        bit_idx <= '0;
                        state   <= DATA_BITS;
                    end
                end
                DATA_BITS: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            uart_tx <= 1'b1;
                            state   <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= cur_byte[bit_idx + 3'd1];
                        end
                    end
                end
                STOP_BIT: begin
                    if (tick) begin
                        if (idx != LAST_IDX) begin
                            idx     <= idx + IDX_W'(1);
                            uart_tx <= 1'b0;
                            state   <= START_BIT;
                        end else begin
                            done <= 1'b1;
                            // a held start chains the next dump with no idle gap
                            if (start) begin
                                shadow  <= par_data;
                                idx     <= '0;
                                bit_idx <= '0;
                                uart_tx <= 1'b0;
                                state   <= START_BIT;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conf_uart_tx.sv
// Scoreboard bench for conf_uart_tx with BIT_CLK_MAX=4, CONF_PAR_MAX=2.
// Honours CONF_TX_CHECKSUM_EN for the expected frame count.
module tb_conf_uart_tx;

    localparam int B  = 4;
    localparam int NP = 2;
`ifdef CONF_TX_CHECKSUM_EN
    localparam int NF = NP + 1;
`else
    localparam int NF = NP;
`endif
    localparam int EXP_BUSY = NF * 10 * B;
    localparam int HOLD     = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] par_data;
    logic        uart_tx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int exp_dumps = 0;
    int done_cnt = 0;
    int rst_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    conf_uart_tx #(
        .CONF_PAR_MAX(NP),
        .BIT_CLK_MAX (B)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .par_data(par_data),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done)
    );

    always @(negedge rst_n) rst_cnt++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: a dump is the parameter bytes in order, then their XOR.
    function automatic void push_dump(input logic [15:0] d);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < NP; k++) begin
            exp_q.push_back(d[k*8 +: 8]);
            x = x ^ d[k*8 +: 8];
        end
`ifdef CONF_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        exp_dumps++;
    endfunction

    // Line monitor: decodes 8N1 frames at mid-bit and pops the scoreboard.
    initial begin : line_mon
        logic [7:0] b;
        logic st, stp;
        int r;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                r = rst_cnt;
                repeat (B / 2) @(negedge clk);
                st = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (B) @(negedge clk);
                stp = uart_tx;
                if (r == rst_cnt) begin
                    check("start_bit", 32'(st), 32'd0);
                    check("stop_bit", 32'(stp), 32'd1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame_unexpected: got %02h required none", b);
                    end else begin
                        check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // Busy/done monitor: every completed dump lasts exactly EXP_BUSY cycles.
    initial begin : busy_mon
        int cnt;
        int r;
        cnt = 0;
        r = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                check("dump_len", 32'(cnt), 32'(EXP_BUSY));
                cnt = (busy === 1'b1) ? 1 : 0;
                r = rst_cnt;
            end else if (busy === 1'b1) begin
                if (cnt == 0) r = rst_cnt;
                cnt++;
            end else begin
                if (cnt != 0)
                    check("busy_drop_only_on_reset", 32'(rst_cnt != r), 32'd1);
                cnt = 0;
            end
        end
    end

    initial begin
        logic [15:0] d;
        int k, n, run, maxrun;
        rst_n = 1'b0;
        start = 1'b0;
        par_data = '0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_uart_tx", 32'(uart_tx), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);

        // Single dump with a mid-dump data change and an ignored start.
        par_data = 16'hA53C;
        start = 1'b1;
        push_dump(16'hA53C);
        @(negedge clk);
        start = 1'b0;
        check("busy_latency", 32'(busy), 32'd1);
        check("start_latency", 32'(uart_tx), 32'd0);
        for (int i = 1; i <= 81; i++) begin
            @(negedge clk);
            if (i == 19) begin
                par_data = 16'hFFFF;
                start = 1'b1;
            end
            if (i == 20) start = 1'b0;
            if (i == EXP_BUSY - 1) begin
                check("busy_before_end", 32'(busy), 32'd1);
                check("no_early_done", 32'(done), 32'd0);
            end
            if (i == EXP_BUSY) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_clear_on_done", 32'(busy), 32'd0);
            end
            if (i == EXP_BUSY + 1) check("done_one_cycle", 32'(done), 32'd0);
        end
        repeat (EXP_BUSY) @(negedge clk);

        // Randomized dumps, sometimes with a change + start while busy.
        for (int j = 0; j < 6; j++) begin
            d = 16'($urandom);
            par_data = d;
            start = 1'b1;
            push_dump(d);
            @(negedge clk);
            start = 1'b0;
            k = int'($urandom_range(1, EXP_BUSY - 3));
            repeat (k) @(negedge clk);
            par_data = 16'($urandom);
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
            repeat (EXP_BUSY - k) @(negedge clk);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Start held high: back-to-back dumps with no idle between frames.
        par_data = 16'h2412;
        n = (HOLD - 1) / EXP_BUSY + 1;
        for (int j = 0; j < n; j++) push_dump(16'h2412);
        start = 1'b1;
        run = 0;
        maxrun = 0;
        for (int i = 0; i <= n * EXP_BUSY + 5; i++) begin
            @(negedge clk);
            if (i == HOLD - 1) start = 1'b0;
            if (i >= 1 && i <= n * EXP_BUSY - 1) begin
                run = (uart_tx === 1'b1) ? run + 1 : 0;
                if (run > maxrun) maxrun = run;
            end
        end
        check("max_high_run", 32'(maxrun), 32'(B));
        repeat (10) @(negedge clk);

        // Reset during a zero data bit.
        par_data = 16'hFF00;
        start = 1'b1;
        push_dump(16'hFF00);
        @(negedge clk);
        start = 1'b0;
        repeat (B + 2) @(negedge clk);
        check("line_low_before_reset", 32'(uart_tx), 32'd0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_dumps--;
        #1;
        check("abort_uart_tx", 32'(uart_tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);

        d = 16'($urandom);
        par_data = d;
        start = 1'b1;
        push_dump(d);
        @(negedge clk);
        start = 1'b0;
        repeat (EXP_BUSY + 20) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(exp_dumps));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
